// File: rtl/axi_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_fifo_pkg
//  Description : Shared constants and helpers for the AXI channel FIFO.
//                Holds the default payload and address widths and a
//                function that turns an address width into a depth.
//  Revision    : 1.0  initial release
// ============================================================================
package axi_fifo_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 2;

  // Number of storage entries addressed by an ADDR_W-bit index.
  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage : axi_fifo_pkg
`default_nettype wire

// File: rtl/chan_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : chan_fifo_mem
//  Description : FIFO storage array. One synchronous write port and one
//                asynchronous (combinational) read port. Contents are not
//                reset.
//  Ports       : clk     - clock, write on rising edge
//                i_we    - write enable
//                i_waddr - write index
//                i_wdata - write payload
//                i_raddr - read index
//                o_rdata - read payload (combinational)
//  Revision    : 1.0  initial release
// ============================================================================
module chan_fifo_mem
  import axi_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int C_DEPTH = fifo_depth(ADDR_W);

  logic [DATA_W-1:0] r_mem_q [C_DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem_q[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem_q[i_raddr];

endmodule : chan_fifo_mem
`default_nettype wire

// File: rtl/axi_chan_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : axi_chan_fifo
//  Description : First-word-fall-through valid/ready FIFO for one AXI
//                channel. Pointers carry an extra wrap bit so full and empty
//                are distinguished without a separate counter.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                flush             - discard all stored entries
//                s_valid/s_ready/s_data - write side handshake and payload
//                m_valid/m_ready/m_data - read side handshake and payload
//                count             - occupancy 0..DEPTH
//                almost_full       - count >= AFULL_LVL
//  Revision    : 1.0  initial release
// ============================================================================
module axi_chan_fifo
  import axi_fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int AFULL_LVL = fifo_depth(ADDR_W) - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [ADDR_W:0]   count,
  output logic              almost_full
);

  // AFULL_LVL lies in 1..DEPTH, which always fits in ADDR_W+1 bits.
  localparam logic [ADDR_W:0] C_AFULL = AFULL_LVL[ADDR_W:0];
  localparam logic [ADDR_W:0] C_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] r_wptr_q, w_wptr_d;
  logic [ADDR_W:0] r_rptr_q, w_rptr_d;
  logic            w_empty;
  logic            w_full;
  logic            w_push;
  logic            w_pop;

  assign w_empty = (r_wptr_q == r_rptr_q);
  // Same slot index but opposite lap means the writer is a full lap ahead.
  assign w_full  = (r_wptr_q[ADDR_W-1:0] == r_rptr_q[ADDR_W-1:0]) &&
                   (r_wptr_q[ADDR_W]     != r_rptr_q[ADDR_W]);

  // Flush suppresses both handshakes so storage is not touched that cycle.
  assign w_push = s_valid && !w_full  && !flush;
  assign w_pop  = m_ready && !w_empty && !flush;

  always_comb begin
    w_wptr_d = r_wptr_q;
    w_rptr_d = r_rptr_q;
    if (flush) begin
      w_wptr_d = '0;
      w_rptr_d = '0;
    end else begin
      if (w_push) w_wptr_d = r_wptr_q + C_ONE;
      if (w_pop)  w_rptr_d = r_rptr_q + C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr_q <= '0;
      r_rptr_q <= '0;
    end else begin
      r_wptr_q <= w_wptr_d;
      r_rptr_q <= w_rptr_d;
    end
  end

  chan_fifo_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr_q[ADDR_W-1:0]),
    .i_wdata (s_data),
    .i_raddr (r_rptr_q[ADDR_W-1:0]),
    .o_rdata (m_data)
  );

  assign s_ready     = !w_full;
  assign m_valid     = !w_empty;
  assign count       = r_wptr_q - r_rptr_q;
  assign almost_full = (count >= C_AFULL);

endmodule : axi_chan_fifo
`default_nettype wire

// File: tb/tb_axi_chan_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_chan_fifo
//  Description : Self-checking bench for axi_chan_fifo (DEPTH=4, AFULL=3).
//                A directed vector table drives inputs each cycle and checks
//                the outputs seen in that cycle before the clock edge; a
//                short randomized run is then checked against a queue model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_chan_fifo;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic [ADDR_W:0]   count;
  logic              almost_full;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axi_chan_fifo #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .AFULL_LVL (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .count       (count),
    .almost_full (almost_full)
  );

  // One row = inputs for this cycle plus outputs expected in this cycle
  // (before the edge). chk=0 skips checks; dchk=0 skips the data check.
  typedef struct {
    logic        rst, flush, sv;
    logic [31:0] d;
    logic        mr, chk;
    logic [2:0]  cnt;
    logic        mv, sr, af, dchk;
    logic [31:0] dat;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, f, sv, input logic [31:0] d,
                              input logic mr, chk, input logic [2:0] cnt,
                              input logic mv, sr, af, dchk,
                              input logic [31:0] dat);
    vec_t v;
    v.rst = r; v.flush = f; v.sv = sv; v.d = d; v.mr = mr; v.chk = chk;
    v.cnt = cnt; v.mv = mv; v.sr = sr; v.af = af; v.dchk = dchk; v.dat = dat;
    return v;
  endfunction

  task automatic cmp(input string nm, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row=%0d got=%0h want=%0h", nm, row, act, exp);
    end
  endtask

  logic [31:0] model_q[$];
  logic [31:0] exp_d;

  initial begin
    rst = 1'b1; flush = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;

    //          rst f  sv data   mr chk cnt mv sr af dchk data
    // Reset, then fill with A0..A3 while m_ready=0.
    vq.push_back(mk(1, 0, 0, 32'h00, 0, 0, 0, 0, 0, 0, 0, 32'h00));
    vq.push_back(mk(0, 0, 1, 32'hA0, 0, 1, 0, 0, 1, 0, 0, 32'h00));
    vq.push_back(mk(0, 0, 1, 32'hA1, 0, 1, 1, 1, 1, 0, 1, 32'hA0));
    vq.push_back(mk(0, 0, 1, 32'hA2, 0, 1, 2, 1, 1, 0, 1, 32'hA0));
    vq.push_back(mk(0, 0, 1, 32'hA3, 0, 1, 3, 1, 1, 1, 1, 32'hA0));
    // Full: offer FF while popping; FF must not be taken.
    vq.push_back(mk(0, 0, 1, 32'hFF, 1, 1, 4, 1, 0, 1, 1, 32'hA0));
    vq.push_back(mk(0, 0, 0, 32'h00, 0, 1, 3, 1, 1, 1, 1, 32'hA1));
    vq.push_back(mk(0, 0, 0, 32'h00, 1, 1, 3, 1, 1, 1, 1, 32'hA1));
    // count=2: ten cycles of simultaneous push/pop across pointer wrap.
    vq.push_back(mk(0, 0, 1, 32'hB0, 1, 1, 2, 1, 1, 0, 1, 32'hA2));
    vq.push_back(mk(0, 0, 1, 32'hB1, 1, 1, 2, 1, 1, 0, 1, 32'hA3));
    for (int k = 2; k < 10; k++)
      vq.push_back(mk(0, 0, 1, 32'hB0 + k, 1, 1, 2, 1, 1, 0, 1, 32'hB0 + k - 2));
    vq.push_back(mk(0, 0, 0, 32'h00, 1, 1, 2, 1, 1, 0, 1, 32'hB8));
    vq.push_back(mk(0, 0, 0, 32'h00, 1, 1, 1, 1, 1, 0, 1, 32'hB9));
    vq.push_back(mk(0, 0, 0, 32'h00, 0, 1, 0, 0, 1, 0, 0, 32'h00));
    // Empty: push 55 with m_ready=1; no bypass, visible next cycle.
    vq.push_back(mk(0, 0, 1, 32'h55, 1, 1, 0, 0, 1, 0, 0, 32'h00));
    vq.push_back(mk(0, 0, 0, 32'h00, 1, 1, 1, 1, 1, 0, 1, 32'h55));
    vq.push_back(mk(0, 0, 0, 32'h00, 0, 1, 0, 0, 1, 0, 0, 32'h00));
    // Fill to 3, then flush together with push and pop.
    vq.push_back(mk(0, 0, 1, 32'hC0, 0, 1, 0, 0, 1, 0, 0, 32'h00));
    vq.push_back(mk(0, 0, 1, 32'hC1, 0, 1, 1, 1, 1, 0, 1, 32'hC0));
    vq.push_back(mk(0, 0, 1, 32'hC2, 0, 1, 2, 1, 1, 0, 1, 32'hC0));
    vq.push_back(mk(0, 1, 1, 32'hC3, 1, 1, 3, 1, 1, 1, 1, 32'hC0));
    vq.push_back(mk(0, 0, 0, 32'h00, 0, 1, 0, 0, 1, 0, 0, 32'h00));
    // Fill to 3, then reset with push and pop active, then reuse.
    vq.push_back(mk(0, 0, 1, 32'hD0, 0, 1, 0, 0, 1, 0, 0, 32'h00));
    vq.push_back(mk(0, 0, 1, 32'hD1, 0, 1, 1, 1, 1, 0, 1, 32'hD0));
    vq.push_back(mk(0, 0, 1, 32'hD2, 0, 1, 2, 1, 1, 0, 1, 32'hD0));
    vq.push_back(mk(1, 0, 1, 32'hD3, 1, 1, 3, 1, 1, 1, 1, 32'hD0));
    vq.push_back(mk(0, 0, 1, 32'hE0, 0, 1, 0, 0, 1, 0, 0, 32'h00));
    vq.push_back(mk(0, 0, 1, 32'hE1, 0, 1, 1, 1, 1, 0, 1, 32'hE0));
    vq.push_back(mk(0, 0, 0, 32'h00, 1, 1, 2, 1, 1, 0, 1, 32'hE0));
    vq.push_back(mk(0, 0, 0, 32'h00, 1, 1, 1, 1, 1, 0, 1, 32'hE1));
    vq.push_back(mk(0, 0, 0, 32'h00, 0, 1, 0, 0, 1, 0, 0, 32'h00));

    @(posedge clk); #1;
    for (int i = 0; i < vq.size(); i++) begin
      rst = vq[i].rst; flush = vq[i].flush; s_valid = vq[i].sv;
      s_data = vq[i].d; m_ready = vq[i].mr;
      #2;
      if (vq[i].chk) begin
        cmp("count",       i, 32'(count),       32'(vq[i].cnt));
        cmp("m_valid",     i, 32'(m_valid),     32'(vq[i].mv));
        cmp("s_ready",     i, 32'(s_ready),     32'(vq[i].sr));
        cmp("almost_full", i, 32'(almost_full), 32'(vq[i].af));
        if (vq[i].dchk) cmp("m_data", i, m_data, vq[i].dat);
      end
      @(posedge clk); #1;
    end

    // Randomized handshake run against a queue model (FIFO is empty here).
    rst = 1'b0; flush = 1'b0;
    for (int c = 0; c < 200; c++) begin
      s_valid = 1'($urandom_range(0, 1));
      m_ready = 1'($urandom_range(0, 1));
      s_data  = $urandom;
      #2;
      cmp("rnd_count",   1000 + c, 32'(count),   32'(model_q.size()));
      cmp("rnd_s_ready", 1000 + c, 32'(s_ready), 32'(model_q.size() < 4));
      if (m_valid && m_ready) begin
        exp_d = model_q.pop_front();
        cmp("rnd_m_data", 1000 + c, m_data, exp_d);
      end
      if (s_valid && s_ready) model_q.push_back(s_data);
      @(posedge clk); #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_axi_chan_fifo
`default_nettype wire
